// File: rtl/ffe_weight_loader_pkg.sv
// Shared types and constants for the FFE weight-memory loader.
// Broadcast support is enabled by defining FFE_LOADER_BCAST_EN.
package ffe_loader_pkg;

  localparam int FFE_LENGTH = 10;
  localparam int FFE_WIDTH  = 16;
  localparam int FFE_WPREC  = 10;

  localparam int WR_COUNT_W = 16;
  localparam logic INST_MODE_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    EXEC    = 2'd2,
    RELEASE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/ffe_weight_loader_if.sv
// Valid/ready request channel into the FFE weight loader.
// req_bcast is only honoured when FFE_LOADER_BCAST_EN is defined.
interface ffe_weight_loader_if
  import ffe_loader_pkg::*;
#(
  parameter int DW    = $clog2(FFE_LENGTH),
  parameter int WW    = $clog2(FFE_WIDTH),
  parameter int WPREC = FFE_WPREC
) ();

  logic             req_valid;
  logic             req_ready;
  logic [DW-1:0]    req_depth;
  logic [WW-1:0]    req_width;
  logic [WPREC-1:0] req_value;
  logic             req_bcast;

  modport master (
    output req_valid,
    output req_depth,
    output req_width,
    output req_value,
    output req_bcast,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_depth,
    input  req_width,
    input  req_value,
    input  req_bcast,
    output req_ready
  );

endinterface

// File: rtl/ffe_weight_loader.sv
// Sequences single or broadcast writes into the FFE weight memory.
// Define FFE_LOADER_BCAST_EN to enable the all-slice broadcast mode.
module ffe_weight_loader
  import ffe_loader_pkg::*;
#(
  parameter int LENGTH = FFE_LENGTH,
  parameter int WIDTH  = FFE_WIDTH,
  parameter int WPREC  = FFE_WPREC,
  parameter int DW     = $clog2(LENGTH),
  parameter int WW     = $clog2(WIDTH)
) (
  input  logic                  clk_adc,
  input  logic                  rst,
  ffe_weight_loader_if.slave    req,
  output logic [WW+DW:0]        wme_ffe_inst,
  output logic [WPREC-1:0]      wme_ffe_data,
  output logic                  wme_ffe_exec,
  output logic                  busy,
  output logic                  done,
  output logic                  req_err,
  output logic [WR_COUNT_W-1:0] wr_count
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_SETUP   = SETUP;
  localparam logic [1:0] S_EXEC    = EXEC;
  localparam logic [1:0] S_RELEASE = RELEASE;

  localparam logic [DW:0] LEN_L = (DW+1)'(LENGTH);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          ready_q;
  logic          accept;
  logic          bad_depth;
  logic          more;
  logic [WW-1:0] width_sel;

  assign accept    = req.req_valid && ready_q;
  assign bad_depth = {1'b0, req.req_depth} >= LEN_L;
  assign busy      = (state != S_IDLE);
  assign req.req_ready = ready_q;

`ifdef FFE_LOADER_BCAST_EN
  localparam logic [WW-1:0] W_LAST = WW'(WIDTH - 1);

  logic          bcast_q;
  logic [WW-1:0] widx;

  assign width_sel = req.req_bcast ? '0 : req.req_width;
  assign more      = bcast_q && (widx != W_LAST);

  // Slice counter walks 0..WIDTH-1 during a broadcast
  always_ff @(posedge clk_adc) begin
    if (rst) begin
      bcast_q <= 1'b0;
      widx    <= '0;
    end else if (accept && !bad_depth) begin
      bcast_q <= req.req_bcast;
      widx    <= width_sel;
    end else if (state == S_RELEASE && more) begin
      widx    <= widx + WW'(1);
    end
  end
`else
  logic unused_bcast;

  assign unused_bcast = req.req_bcast;
  assign width_sel    = req.req_width;
  assign more         = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (accept && !bad_depth) state_nx = S_SETUP;
      S_SETUP:   state_nx = S_EXEC;
      S_EXEC:    state_nx = S_RELEASE;
      S_RELEASE: state_nx = more ? S_SETUP : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_adc) begin
    if (rst) begin
      state        <= S_IDLE;
      ready_q      <= 1'b0;
      wme_ffe_inst <= '0;
      wme_ffe_data <= '0;
      wme_ffe_exec <= 1'b0;
      done         <= 1'b0;
      req_err      <= 1'b0;
      wr_count     <= '0;
    end else begin
      state        <= state_nx;
      ready_q      <= (state_nx == S_IDLE);
      wme_ffe_exec <= (state == S_SETUP);
      done         <= (state == S_EXEC) && !more;
      req_err      <= accept && bad_depth;
      if (state == S_SETUP && wr_count != '1)
        wr_count <= wr_count + WR_COUNT_W'(1);
      // Inst/data move only on entry to SETUP, so they bracket exec
      if (accept && !bad_depth) begin
        wme_ffe_inst <= {INST_MODE_WRITE, width_sel, req.req_depth};
        wme_ffe_data <= req.req_value;
      end
`ifdef FFE_LOADER_BCAST_EN
      else if (state == S_RELEASE && more) begin
        wme_ffe_inst <= {INST_MODE_WRITE, widx + WW'(1),
                         wme_ffe_inst[DW-1:0]};
      end
`endif
    end
  end

endmodule

// File: doc/ffe_weight_loader.md
# ffe_weight_loader

Sequences writes into the FFE weight memory in the digital core. It accepts single-weight load requests over a valid/ready handshake and drives the weight-memory instruction, data and exec lines with setup and hold margins. An optional broadcast mode writes one value to a given tap across all channel slices. It replaces per-weight manual poking of the weight-memory instruction, data and exec fields with one sequenced on-chip controller.

## Interface
Parameters:
- `LENGTH`, 10: FFE taps per slice (depth).
- `WIDTH`, 16: channel slices (width).
- `WPREC`, 10: weight precision in bits.
- `DW`, `$clog2(LENGTH)`: depth-index width (derived).
- `WW`, `$clog2(WIDTH)`: width-index width (derived).

Ports:
- `clk_adc`  in  1: the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: load request present.
- `req_ready`  out  1: loader can accept a request.
- `req_depth`  in  DW: tap index.
- `req_width`  in  WW: slice index. Ignored on broadcast.
- `req_value`  in  WPREC: signed weight.
- `req_bcast`  in  1: write all slices (`FFE_LOADER_BCAST_EN` only).
- `wme_ffe_inst`  out  1+WW+DW: `{mode=0, width_idx, depth_idx}`.
- `wme_ffe_data`  out  WPREC: weight value.
- `wme_ffe_exec`  out  1: write strobe.
- `busy`  out  1: FSM not in IDLE.
- `done`  out  1: one-cycle pulse when a request completes.
- `req_err`  out  1: one-cycle pulse when a request is rejected.
- `wr_count`  out  16: saturating count of exec strobes issued.

## Operation
States and transitions:
- IDLE: `req_ready`=1. On `req_valid`, capture depth, width, value and bcast; then:
  - if `req_depth >= LENGTH`, pulse `req_err` next cycle and stay in IDLE;
  - otherwise go to SETUP.
- SETUP: drive `wme_ffe_inst` and `wme_ffe_data`; `wme_ffe_exec`=0. Go to EXEC.
- EXEC: `wme_ffe_exec`=1 for exactly one cycle; inst and data unchanged. `wr_count`+1, saturating at 16'hFFFF. Go to RELEASE.
- RELEASE: exec=0; inst and data still held.
  - If broadcast and width index < WIDTH-1: increment the index, go to SETUP.
  - Otherwise pulse `done` and go to IDLE.

Datapath rules:
- Broadcast writes slices 0..WIDTH-1 in ascending order, each with the same depth and value.
- The `wme_ffe_inst` MSB (mode bit) is always 0.
- Inst and data are registered and change only on entry to SETUP. They hold their last value while in IDLE.
- `req_width` needs no range check, because WIDTH is a power of two.

Reset:
- All outputs go to 0 on the cycle after `rst` is sampled high, with one exception: `req_ready` is 0 during reset and 1 from the first cycle after `rst` falls.
- Reset mid-sequence abandons the transfer: exec is forced to 0, the FSM returns to IDLE, no `done` is issued, and `wr_count` is cleared.

## Timing
- Handshake: transfer happens on a cycle where `req_valid && req_ready`. `req_ready` is registered and equals (state==IDLE && !rst). There is no combinational path from `req_valid` to `req_ready`.
- Single write, request accepted at cycle 0:
  - cycle 1: SETUP;
  - cycle 2: EXEC (exec high);
  - cycle 3: RELEASE, with `done`;
  - cycle 4: `req_ready`=1.
  - Throughput is one write per 4 cycles.
- Broadcast: 3·WIDTH cycles from SETUP of slice 0 to `done`; exec pulses are 3 cycles apart.
- Rejected request: `req_err` at cycle 1; `req_ready` stays 1, so a new request can be accepted at cycle 1.
- Inst and data are stable at least 1 cycle before and 1 cycle after each exec-high cycle.

## Configuration
- `FFE_LOADER_BCAST_EN` defined: `req_bcast` is honoured and the width-index counter is instantiated.
- Not defined: `req_bcast` is ignored (treated as 0), every request is a single write, and the counter logic is removed.

## Structure
- Shared package `ffe_loader_pkg`:
  - state enum `loader_state_t` {IDLE, SETUP, EXEC, RELEASE};
  - `WR_COUNT_W`=16;
  - `INST_MODE_WRITE`=1'b0.
- Default LENGTH, WIDTH and WPREC come from the existing FFE and constant packages.
- Single module with no sub-module. The FSM and the index counter are small enough to stay flat.

## Test plan
- Single write: depth=1, width=3, value=-115 → `wme_ffe_inst`={0,4'd3,4'd1} from cycle 1, exec high only at cycle 2, `done` at cycle 3, `wr_count`=1.
- Broadcast (macro on): depth=0, value=+250 → 16 exec pulses spaced 3 cycles apart, width idx 0..15 in order, single `done` at cycle 48, `wr_count`=16.
- Out-of-range depth=12 → `req_err` pulse, no exec, `wr_count` unchanged, new request accepted the next cycle.
- Back-to-back requests with `req_valid` held high → accepts at cycles 0 and 4, no exec overlap, `req_ready` low on cycles 1–3.
- Reset asserted during the EXEC of broadcast slice 5 → exec low the next cycle, no `done`, all outputs 0, `req_ready`=1 after reset falls.
- Macro off, `req_bcast`=1, width=7 → exactly one exec, with width idx 7.
